uart_tx: RTL

Serial transmit engine for the UART peripheral. Sits directly downstream of the TX `fifo` instance, which is standard-mode, not first-word-fallthrough. It pops one byte at a time, using the FIFO's one-cycle read latency, and serializes each byte as an 8N1 or 8N2 frame on `tx` at a CSR-programmed baud rate. The block owns the FIFO read port; the bus side owns the write port.

---
 rtl/uart_tx.sv | 127 ++++++++++++
 1 files changed

// File: rtl/uart_tx.sv
// UART transmit engine: pops bytes from a standard-mode TX FIFO (one-cycle read
// latency) and serializes each as start + DATA_BITS (LSB first) + STOP_BITS frame.
module uart_tx #(
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1,
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [DIV_WIDTH-1:0] baud_div,
  input  logic                 fifo_empty,
  input  logic [DATA_BITS-1:0] fifo_dout,
  output logic                 fifo_rd_en,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);

  localparam int BIT_W = (DATA_BITS > 2) ? $clog2(DATA_BITS) : 2;
  localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [DIV_WIDTH-1:0] r_div;
  logic [DIV_WIDTH-1:0] r_cnt;
  logic [BIT_W-1:0]     r_bit;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_tx;
  logic                 r_busy;
  logic                 r_done;
  logic                 w_rd_en;
  logic                 w_bit_tick;
  logic                 w_tx_next;

  // Pop is gated by reset so nothing is consumed while the block is held in reset.
  always_comb begin
    w_state_next = r_state;
    w_bit_tick   = (r_cnt == r_div);
    w_rd_en      = rst_n && en && !fifo_empty && (r_state == S_IDLE);
    case (r_state)
      S_IDLE:  if (w_rd_en) w_state_next = S_FETCH;
      S_FETCH: w_state_next = S_START;
      S_START: if (w_bit_tick) w_state_next = S_DATA;
      S_DATA:  if (w_bit_tick && (r_bit == LAST_DATA)) w_state_next = S_STOP;
      S_STOP:  if (w_bit_tick && (r_bit == LAST_STOP)) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase

    // tx is registered, so it is computed from the state being entered.
    w_tx_next = 1'b1;
    case (w_state_next)
      S_START: w_tx_next = 1'b0;
      S_DATA: begin
        if (r_state == S_START) w_tx_next = r_shift[0];
        else if (w_bit_tick)    w_tx_next = r_shift[1];
        else                    w_tx_next = r_tx;
      end
      default: w_tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_tx    <= w_tx_next;
      r_busy  <= (w_state_next != S_IDLE);
      r_done  <= (r_state == S_STOP) && (w_state_next == S_IDLE);
    end
  end

  // Divider latched per frame; the cycle counter never runs past it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_div   <= '0;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      case (r_state)
        S_FETCH: begin
          r_div   <= baud_div;
          r_cnt   <= '0;
          r_bit   <= '0;
          r_shift <= fifo_dout;
        end
        S_START, S_DATA, S_STOP: begin
          if (w_bit_tick) begin
            r_cnt <= '0;
            if (r_state == S_DATA) begin
              r_shift <= r_shift >> 1;
              r_bit   <= (r_bit == LAST_DATA) ? '0 : r_bit + 1'b1;
            end else if (r_state == S_STOP) begin
              r_bit <= (r_bit == LAST_STOP) ? '0 : r_bit + 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_cnt <= '0;
          r_bit <= '0;
        end
      endcase
    end
  end

  assign fifo_rd_en = w_rd_en;
  assign tx         = r_tx;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule
